// File: rtl/timer_keypad_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// timer_keypad_ctrl_pkg
// Shared definitions for the keypad/panel controller of the countdown timer:
// controller state encoding, key index map into the debounced press vector,
// digit counter limit and small helpers for the digit encoder.
// -----------------------------------------------------------------------------
package timer_keypad_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Bits 0..9 of the press vector are the digit keys.
  localparam int NUM_DIGITS = 10;
  localparam int KEY_START  = 10;
  localparam int KEY_STOP   = 11;
  localparam int KEY_CLEAR  = 12;
  localparam int NUM_KEYS   = 13;

  // The digit counter saturates here; further digits are ignored.
  localparam logic [1:0] DIGIT_LIMIT = 2'd3;

  // True when exactly one digit press is present in the cycle.
  function automatic logic digit_onehot(input logic [NUM_DIGITS-1:0] p);
    int ones;
    ones = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (p[i]) ones++;
    end
    return (ones == 1);
  endfunction

  // Index of the set digit bit; only meaningful when digit_onehot() holds.
  function automatic logic [3:0] digit_encode(input logic [NUM_DIGITS-1:0] p);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (p[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/timer_keypad_ctrl_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Two-flop synchronizer followed by a stability counter for one raw key.
// The accepted level only changes after the synchronized level has differed
// from it for DEBOUNCE_CYCLES consecutive cycles; press is a single-cycle
// pulse on the cycle a new high level is accepted.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   key_raw     - raw key level, asynchronous to clk
//   press       - one-cycle press pulse
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        // Any return to the accepted level restarts the stability window.
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
        press_reg <= sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/timer_keypad_ctrl.sv
// -----------------------------------------------------------------------------
// timer_keypad_ctrl
// Drives the countdown timer's command interface from keypad and panel
// buttons: debounced digit entry (up to three BCD digits shifted in), a
// run/pause/done machine, the divided decrement enable and the done beep.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   key_digit[9:0]      - raw digit keys
//   key_start/stop/clear- raw panel buttons
//   door_closed         - interlock level (synchronized, not debounced)
//   zerado              - timer shows 0:00
//   data[3:0], load     - BCD digit and its one-cycle shift-in pulse
//   en                  - one-cycle decrement pulse
//   clear               - one-cycle timer clear pulse
//   mag_on, beep        - decoded RUN / DONE
// -----------------------------------------------------------------------------
module timer_keypad_ctrl
  import timer_keypad_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int TICK_DIV        = 50_000_000,
  parameter int BEEP_CYCLES     = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_digit,
  input  logic       key_start,
  input  logic       key_stop,
  input  logic       key_clear,
  input  logic       door_closed,
  input  logic       zerado,
  output logic [3:0] data,
  output logic       load,
  output logic       en,
  output logic       clear,
  output logic       mag_on,
  output logic       beep
);

  localparam int TW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  logic [NUM_KEYS-1:0] keys_raw;
  logic [NUM_KEYS-1:0] press_vec;

  assign keys_raw = {key_clear, key_stop, key_start, key_digit};

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_raw(keys_raw[gi]),
        .press  (press_vec[gi])
      );
    end
  endgenerate

  logic door1_reg, door2_reg;

  state_t        state_reg, state_next;
  logic [1:0]    digit_cnt_reg, digit_cnt_next;
  logic [3:0]    data_reg, data_next;
  logic          load_reg, load_next;
  logic          clear_reg, clear_next;
  logic          en_reg;
  logic [TW-1:0] tick_cnt_reg;
  logic [BW-1:0] beep_cnt_reg;

  logic start_p, stop_p, clear_p, tick, beep_done, can_run;

  assign start_p   = press_vec[KEY_START];
  assign stop_p    = press_vec[KEY_STOP];
  assign clear_p   = press_vec[KEY_CLEAR];
  assign can_run   = start_p && door2_reg && !zerado;
  assign tick      = (state_reg == RUN) && (tick_cnt_reg == TW'(TICK_DIV - 1));
  assign beep_done = (beep_cnt_reg == BW'(BEEP_CYCLES - 1));

  // Event priority: clear > (stop | door open) > zerado > start > digit.
  always_comb begin
    state_next     = state_reg;
    digit_cnt_next = digit_cnt_reg;
    data_next      = data_reg;
    load_next      = 1'b0;
    clear_next     = 1'b0;
    if (clear_p) begin
      state_next     = IDLE;
      digit_cnt_next = 2'd0;
      clear_next     = 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (can_run) begin
            state_next = RUN;
          end else if (!start_p && digit_onehot(press_vec[9:0]) &&
                       (digit_cnt_reg < DIGIT_LIMIT)) begin
            load_next      = 1'b1;
            data_next      = digit_encode(press_vec[9:0]);
            digit_cnt_next = digit_cnt_reg + 2'd1;
          end
        end
        RUN: begin
          if (stop_p || !door2_reg) state_next = PAUSE;
          else if (zerado)          state_next = DONE;
        end
        PAUSE: begin
          if (can_run) state_next = RUN;
        end
        DONE: begin
          if (beep_done || (|press_vec)) begin
            state_next     = IDLE;
            digit_cnt_next = 2'd0;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      door1_reg     <= 1'b0;
      door2_reg     <= 1'b0;
      state_reg     <= IDLE;
      digit_cnt_reg <= 2'd0;
      data_reg      <= 4'd0;
      load_reg      <= 1'b0;
      clear_reg     <= 1'b0;
      en_reg        <= 1'b0;
      tick_cnt_reg  <= '0;
      beep_cnt_reg  <= '0;
    end else begin
      door1_reg     <= door_closed;
      door2_reg     <= door1_reg;
      state_reg     <= state_next;
      digit_cnt_reg <= digit_cnt_next;
      data_reg      <= data_next;
      load_reg      <= load_next;
      clear_reg     <= clear_next;
      en_reg        <= tick && !zerado;
      // Held at zero outside RUN, so every entry into RUN (and any partial
      // count left by a pause) starts a full tick period.
      if (state_reg != RUN || tick) tick_cnt_reg <= '0;
      else                          tick_cnt_reg <= tick_cnt_reg + 1'b1;
      if (state_reg == DONE) beep_cnt_reg <= beep_cnt_reg + 1'b1;
      else                   beep_cnt_reg <= '0;
    end
  end

  assign data   = data_reg;
  assign load   = load_reg;
  assign clear  = clear_reg;
  assign en     = en_reg;
  assign mag_on = (state_reg == RUN);
  assign beep   = (state_reg == DONE);

endmodule

// File: tb/tb_timer_keypad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_timer_keypad_ctrl
// Directed bench for timer_keypad_ctrl with DEBOUNCE_CYCLES=2, TICK_DIV=4,
// BEEP_CYCLES=6. Expected load digits are queued when a key is driven and
// popped by a negedge monitor when load appears.
// -----------------------------------------------------------------------------
module tb_timer_keypad_ctrl;
  import timer_keypad_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] keys;
  logic        door_closed;
  logic        zerado;
  logic [3:0]  data;
  logic        load, en, clear, mag_on, beep;

  int errors = 0;
  int checks = 0;
  int clears_seen = 0;
  logic clear_prev = 1'b0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  timer_keypad_ctrl #(
    .DEBOUNCE_CYCLES(2),
    .TICK_DIV       (4),
    .BEEP_CYCLES    (6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_digit  (keys[9:0]),
    .key_start  (keys[10]),
    .key_stop   (keys[11]),
    .key_clear  (keys[12]),
    .door_closed(door_closed),
    .zerado     (zerado),
    .data       (data),
    .load       (load),
    .en         (en),
    .clear      (clear),
    .mag_on     (mag_on),
    .beep       (beep)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every load must match the oldest queued digit.
  always @(negedge clk) begin
    logic [3:0] e;
    if (rst_n === 1'b1) begin
      if (load === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("load_unexpected", 32'(load), 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("load data=%0d expected=%0d", data, e);
          chk("load_data", 32'(data), 32'(e));
        end
      end
      if (clear === 1'b1) begin
        clears_seen++;
        $display("clear pulse #%0d", clears_seen);
        chk("clear_with_load", 32'(load), 32'd0);
        chk("clear_width", 32'(clear_prev), 32'd0);
      end
      clear_prev = clear;
    end else begin
      clear_prev = 1'b0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_digit(input int d, input bit expect_load);
    if (expect_load) exp_q.push_back(4'(d));
    keys[d] = 1'b1;
    step(10);
    keys[d] = 1'b0;
    step(8);
  endtask

  task automatic pulse_key(input int idx);
    keys[idx] = 1'b1;
    step(4);
    keys[idx] = 1'b0;
  endtask

  task automatic wait_mag(input logic v, input string tag);
    int n;
    n = 0;
    while (mag_on !== v && n < 30) begin
      step(1);
      n++;
    end
    chk(tag, 32'(mag_on), 32'(v));
  endtask

  // Called right after entry into RUN (or right after an en): three quiet
  // cycles, then en on the fourth.
  task automatic check_en_period(input string tag);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk({tag, "_quiet"}, 32'(en), 32'd0);
    end
    step(1);
    chk({tag, "_tick"}, 32'(en), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_data"},   32'(data),   32'd0);
    chk({tag, "_load"},   32'(load),   32'd0);
    chk({tag, "_en"},     32'(en),     32'd0);
    chk({tag, "_clear"},  32'(clear),  32'd0);
    chk({tag, "_mag_on"}, 32'(mag_on), 32'd0);
    chk({tag, "_beep"},   32'(beep),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic en_any;
    rst_n       = 1'b0;
    keys        = '0;
    door_closed = 1'b1;
    zerado      = 1'b0;
    step(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(3);

    // Simultaneous digits and a short bounce: nothing loads, data holds.
    keys[2] = 1'b1;
    keys[7] = 1'b1;
    step(10);
    keys[2] = 1'b0;
    keys[7] = 1'b0;
    step(8);
    chk("multi_digit_data_hold", 32'(data), 32'd0);
    keys[4] = 1'b1; step(1);
    keys[4] = 1'b0; step(1);
    keys[4] = 1'b1; step(1);
    keys[4] = 1'b0; step(8);
    chk("bounce_data_hold", 32'(data), 32'd0);

    // Three digits load, the fourth is ignored.
    press_digit(1, 1'b1);
    press_digit(3, 1'b1);
    press_digit(0, 1'b1);
    press_digit(5, 1'b0);
    chk("digits_all_loaded", 32'(exp_q.size()), 32'd0);
    chk("fourth_digit_data_hold", 32'(data), 32'd0);

    // Run, decrement cadence, zerado stops en, done beep, back to idle.
    pulse_key(KEY_START);
    wait_mag(1'b1, "run_entry");
    check_en_period("run_en1");
    check_en_period("run_en2");
    step(3);
    chk("pre_zero_quiet", 32'(en), 32'd0);
    zerado = 1'b1;
    step(1);
    chk("en_gated_by_zerado", 32'(en), 32'd0);
    chk("done_mag_off", 32'(mag_on), 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("done_beep_on", 32'(beep), 32'd1);
      if (i < 5) step(1);
    end
    step(1);
    chk("done_beep_off", 32'(beep), 32'd0);
    zerado = 1'b0;
    press_digit(8, 1'b1);
    chk("idle_after_done_counter_reset", 32'(exp_q.size()), 32'd0);

    // Door opens in RUN: pause with no en; resume restarts the tick.
    pulse_key(KEY_START);
    wait_mag(1'b1, "run_entry2");
    check_en_period("run2_en");
    door_closed = 1'b0;
    wait_mag(1'b0, "pause_on_door_open");
    en_any = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      en_any = en_any | en;
    end
    chk("pause_no_en", 32'(en_any), 32'd0);
    chk("pause_no_beep", 32'(beep), 32'd0);
    door_closed = 1'b1;
    step(3);
    pulse_key(KEY_START);
    wait_mag(1'b1, "resume_run");
    check_en_period("resume_en");

    // Clear and stop together: clear wins, counter reset to 0.
    clears_seen = 0;
    keys[KEY_CLEAR] = 1'b1;
    keys[KEY_STOP]  = 1'b1;
    step(4);
    keys[KEY_CLEAR] = 1'b0;
    keys[KEY_STOP]  = 1'b0;
    wait_mag(1'b0, "clear_leaves_run");
    step(8);
    chk("clear_pulse_count", 32'(clears_seen), 32'd1);
    press_digit(6, 1'b1);
    press_digit(2, 1'b1);
    press_digit(9, 1'b1);
    press_digit(4, 1'b0);
    chk("after_clear_loads", 32'(exp_q.size()), 32'd0);
    chk("after_clear_data", 32'(data), 32'd9);

    // Asynchronous reset mid-RUN, then start blocked by zerado.
    pulse_key(KEY_START);
    wait_mag(1'b1, "run_entry3");
    step(2);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    step(2);
    rst_n  = 1'b1;
    zerado = 1'b1;
    step(3);
    pulse_key(KEY_START);
    step(12);
    chk("start_blocked_by_zerado", 32'(mag_on), 32'd0);
    chk("start_blocked_no_beep", 32'(beep), 32'd0);
    zerado = 1'b0;
    press_digit(7, 1'b1);
    chk("post_reset_load", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_keypad_ctrl.md
# timer_keypad_ctrl

Control front-end that drives the countdown timer's command interface (`data`, `load`, `en`, `clear`) from raw keypad and panel buttons, and consumes its `zerado` flag. It debounces and encodes ten digit keys into BCD shift-in loads. It runs a four-state run/pause/done machine. It generates the timer's decrement enable at a divided tick rate, gated so the timer never wraps below 0:00.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 8: cycles a synchronized key level must be stable before it is accepted.
- `TICK_DIV`, default 50_000_000: clock cycles per timer decrement (1 s at 50 MHz).
- `BEEP_CYCLES`, default 100_000_000: length of the done beep.

Ports:
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `key_digit` in 10: raw digit keys 0–9, active-high, asynchronous to `clk`.
- `key_start`, `key_stop`, `key_clear` in 1 each: raw panel buttons, active-high.
- `door_closed` in 1: interlock, level, synchronized internally with no debounce.
- `zerado` in 1: timer reports 0:00.
- `data` out 4: BCD digit to shift into the timer.
- `load` out 1: one-cycle pulse; timer shifts `data` in.
- `en` out 1: one-cycle decrement pulse.
- `clear` out 1: one-cycle pulse; timer zeroes.
- `mag_on` out 1: high while in RUN.
- `beep` out 1: high while in DONE.

## Operation
- Every key and button goes through a 2-flop synchronizer and then a stability counter. A key produces one press pulse on the cycle its level has been stable high for `DEBOUNCE_CYCLES`. It re-arms only after the level has been stable low for `DEBOUNCE_CYCLES`. Holding a key yields exactly one pulse.
- Digit encode:
  - If exactly one digit press pulse is present, `data` is that digit.
  - If two or more digit pulses occur in the same cycle, all of them are dropped: no `load`, and `data` holds its value.
- Digit counter: 2 bits, saturating at 3.
  - A digit is accepted only in IDLE with counter < 3.
  - Each accepted digit increments the counter.
  - A fourth digit is ignored.
- States:
  - IDLE, the reset state: digits are accepted.
    - start && door_closed && !zerado → RUN.
    - start while zerado → stays in IDLE.
  - RUN:
    - stop or !door_closed → PAUSE.
    - zerado → DONE.
  - PAUSE:
    - start && door_closed && !zerado → RUN.
    - Digits are ignored.
  - DONE: leaves for IDLE after `BEEP_CYCLES` cycles, or on any key press pulse.
- Clear: a clear press in any state pulses `clear` for one cycle, resets the digit counter, and moves to IDLE.
- Priority when events coincide: clear > (stop | door open) > zerado > start > digit.
- Tick divider:
  - Counts only in RUN.
  - Resets to 0 on every entry into RUN.
  - Asserts its terminal tick when the count reaches `TICK_DIV-1`, then wraps to 0.
  - `en = tick && state==RUN && !zerado`, registered.
- Pause/resume keeps the timer contents, because the controller issues no `clear` or `load` during PAUSE.
- Entering IDLE from DONE resets the digit counter, so a new entry starts fresh.

## Timing
- Reset values: all outputs are 0, `data`=0, state IDLE, every counter 0, every debouncer in the released state.
- Latency from a raw key rising to its press pulse: 2 synchronizer cycles + `DEBOUNCE_CYCLES`. `load`/`clear` are registered, so they appear one cycle later.
- `load` and `clear` are each exactly one cycle wide and never asserted together. `data` is valid in the same cycle as `load`.
- The first `en` after entering RUN occurs `TICK_DIV` cycles after entry. `en` never asserts in the cycle `zerado` is sampled high.
- `mag_on` and `beep` are decoded from the registered state. They change in the cycle after the triggering event.
- Reset mid-operation: state, counters and outputs return to reset values immediately (asynchronous). The timer's contents are not cleared by this block.
- Door opening mid-tick: the state moves to PAUSE and the partial tick count is discarded.

## Structure
- `timer_keypad_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, PAUSE, DONE);
  - the key index constants (KEY_START=10, KEY_STOP=11, KEY_CLEAR=12);
  - the digit counter limit (3).
- Sub-module `key_debounce`, parameterized by `DEBOUNCE_CYCLES`: synchronizer, stability counter and press pulse. It is instantiated 13 times.
- The top holds the encoder, the FSM, the tick divider and the beep counter.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=2, `TICK_DIV`=4, `BEEP_CYCLES`=6.
- Press digits 1, 3, 0 with 10-cycle holds → three `load` pulses with `data`=1, 3, 0; a fourth press of 5 → no `load`.
- Digits 2 and 7 pressed in the same cycle → no `load`; bounce pulse 1-0-1 on digit 4 shorter than 2 cycles → no `load`.
- Start with door closed and zerado=0 → `mag_on`=1; `en` pulses every 4 cycles; force zerado=1 → `en` stops the same cycle, then `beep`=1 for 6 cycles, then IDLE.
- In RUN, drop door_closed → PAUSE, `mag_on`=0, no `en`; close the door and press start → RUN, first `en` 4 cycles later.
- Press clear and stop in the same cycle during RUN → one `clear` pulse, state IDLE, digit counter 0.
- Assert `rst_n`=0 mid-RUN → all outputs 0 immediately; after release, start with zerado=1 → stays in IDLE.
